// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on each side.
// Single-cycle ops finish on the accept edge. Shifts and the unsigned
// multiply step once per EXEC cycle. Result and NZCV flags are held in
// registers until the consumer takes them.
module alu_seq #(
   parameter int BITS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      ALU_Code,
   input  logic [BITS-1:0] A,
   input  logic [BITS-1:0] B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] ALU_Result,
   output logic [3:0]      flags
);

   localparam int SHW = $clog2(BITS) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_SHL = 4'b0100;
   localparam logic [3:0] OP_SHR = 4'b0101;
   localparam logic [3:0] OP_ASR = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1100;

   localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
   localparam logic [SHW-1:0] CNT_BITS = SHW'(BITS);

   // {N,Z,C,V} from a finished result plus carry and overflow
   function automatic logic [3:0] pack_flags(input logic [BITS-1:0] res,
                                             input logic c, input logic v);
      pack_flags = {res[BITS-1], (res == {BITS{1'b0}}), c, v};
   endfunction

   logic [1:0]        state_r;
   logic [3:0]        op_r;
   logic [BITS-1:0]   mcand_r;     // multiplicand
   logic [BITS-1:0]   sh_r;        // value being shifted
   logic [2*BITS-1:0] prod_r;      // {partial product, remaining multiplier}
   logic [SHW-1:0]    cnt_r;       // EXEC steps left
   logic [BITS-1:0]   result_r;
   logic [3:0]        flags_r;

   logic [BITS:0]     add_s;
   logic [BITS:0]     sub_s;
   logic [31:0]       b_wide_s;
   logic [SHW-1:0]    amt_s;
   logic [SHW-1:0]    cnt_load_s;
   logic              is_multi_s;
   logic [BITS-1:0]   sc_res_s;
   logic              sc_c_s;
   logic              sc_v_s;
   logic [BITS-1:0]   sh_next_s;
   logic              sh_c_s;
   logic [BITS:0]     psum_s;
   logic [2*BITS-1:0] prod_next_s;
   logic [BITS-1:0]   fin_res_s;
   logic              fin_c_s;

   assign in_ready   = (state_r == IDLE);
   assign out_valid  = (state_r == DONE);
   assign ALU_Result = result_r;
   assign flags      = flags_r;

   // Single-cycle results and step counts, computed from the live inputs at accept time
   always_comb begin
      add_s      = {1'b0, A} + {1'b0, B};
      sub_s      = {1'b0, A} - {1'b0, B};
      b_wide_s   = 32'(B);
      sc_res_s   = A | B;
      sc_c_s     = 1'b0;
      sc_v_s     = 1'b0;
      is_multi_s = 1'b0;
      if (b_wide_s > 32'(BITS)) begin
         amt_s = CNT_BITS;
      end else begin
         amt_s = b_wide_s[SHW-1:0];
      end
      cnt_load_s = amt_s;
      case (ALU_Code)
         OP_ADD: begin
            sc_res_s = add_s[BITS-1:0];
            sc_c_s   = add_s[BITS];
            sc_v_s   = (A[BITS-1] == B[BITS-1]) && (add_s[BITS-1] != A[BITS-1]);
         end
         OP_SUB: begin
            sc_res_s = sub_s[BITS-1:0];
            sc_c_s   = ~sub_s[BITS];
            sc_v_s   = (A[BITS-1] != B[BITS-1]) && (sub_s[BITS-1] != A[BITS-1]);
         end
         OP_SHL, OP_SHR, OP_ASR: begin
            // only reaches the output when the clamped amount is zero
            sc_res_s   = A;
            is_multi_s = 1'b1;
         end
         OP_MUL: begin
            is_multi_s = 1'b1;
            cnt_load_s = CNT_BITS;
         end
         OP_AND:  sc_res_s = A & B;
         OP_OR:   sc_res_s = A | B;
         OP_XOR:  sc_res_s = A ^ B;
         default: sc_res_s = A | B;
      endcase
   end

   // One shift bit or one shift-add multiply step per EXEC cycle
   always_comb begin
      sh_next_s = sh_r;
      sh_c_s    = 1'b0;
      case (op_r)
         OP_SHL: begin
            sh_next_s = {sh_r[BITS-2:0], 1'b0};
            sh_c_s    = sh_r[BITS-1];
         end
         OP_SHR: begin
            sh_next_s = {1'b0, sh_r[BITS-1:1]};
            sh_c_s    = sh_r[0];
         end
         OP_ASR: begin
            sh_next_s = {sh_r[BITS-1], sh_r[BITS-1:1]};
            sh_c_s    = sh_r[0];
         end
         default: begin
            sh_next_s = sh_r;
            sh_c_s    = 1'b0;
         end
      endcase
      psum_s = {1'b0, prod_r[2*BITS-1:BITS]} + {1'b0, mcand_r};
      if (prod_r[0]) begin
         prod_next_s = {psum_s, prod_r[BITS-1:1]};
      end else begin
         prod_next_s = {1'b0, prod_r[2*BITS-1:1]};
      end
      if (op_r == OP_MUL) begin
         fin_res_s = prod_next_s[BITS-1:0];
         fin_c_s   = |prod_next_s[2*BITS-1:BITS];
      end else begin
         fin_res_s = sh_next_s;
         fin_c_s   = sh_c_s;
      end
   end

   // FSM, operand capture and the held result/flag registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         op_r     <= 4'b0000;
         mcand_r  <= {BITS{1'b0}};
         sh_r     <= {BITS{1'b0}};
         prod_r   <= {(2*BITS){1'b0}};
         cnt_r    <= CNT_ZERO;
         result_r <= {BITS{1'b0}};
         flags_r  <= 4'b0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  op_r    <= ALU_Code;
                  mcand_r <= A;
                  sh_r    <= A;
                  prod_r  <= {{BITS{1'b0}}, B};
                  cnt_r   <= cnt_load_s;
                  if (is_multi_s && (cnt_load_s != CNT_ZERO)) begin
                     state_r <= EXEC;
                  end else begin
                     state_r  <= DONE;
                     result_r <= sc_res_s;
                     flags_r  <= pack_flags(sc_res_s, sc_c_s, sc_v_s);
                  end
               end
            end
            EXEC: begin
               sh_r   <= sh_next_s;
               prod_r <= prod_next_s;
               cnt_r  <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r  <= DONE;
                  result_r <= fin_res_s;
                  flags_r  <= pack_flags(fin_res_s, fin_c_s, 1'b0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
